// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the bus interface.
// Acknowledges each byte with rx_finish and stalls the receiver while full.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_frame_err,
    output logic          rx_finish,
    output logic          rx_full,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [AW:0]   irq_thresh,
    output logic          irq,
    output logic          overflow,
    output logic [7:0]    frame_err_cnt,
    input  logic          clr_status
);

    localparam logic [AW:0] DepthLvl = DEPTH[AW:0];

    typedef enum logic [1:0] {StIdle = 2'd0, StPend = 2'd1, StAck = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   level_q;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    wr_data;
    logic          wr_en, rd_fire, ovf_set, full;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q, overflow_q;
    logic [7:0]    fe_cnt_q;

    assign full    = (level_q == DepthLvl);
    assign rd_fire = rd_en && (level_q != '0);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wr_en     = 1'b0;
        wr_data   = hold_q;
        ovf_set   = 1'b0;
        rx_finish = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_done) begin
                    hold_d = rx_data;
                    if (!full) begin
                        // Write the incoming byte directly; hold_reg is loaded on the same edge.
                        wr_en   = 1'b1;
                        wr_data = rx_data;
                        state_d = StAck;
                    end else begin
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                ovf_set = rx_done;
                if (!full) begin
                    wr_en   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                ovf_set   = rx_done;
                rx_finish = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (wr_en) wp_q <= wp_q + 1'b1;
            if (rd_fire) begin
                rd_data_q <= mem[rp_q];
                rp_q      <= rp_q + 1'b1;
            end
            if (wr_en && !rd_fire)      level_q <= level_q + 1'b1;
            else if (rd_fire && !wr_en) level_q <= level_q - 1'b1;
        end
    end

    // Overflow: set beats clear. Frame error count: clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            fe_cnt_q   <= 8'h00;
        end else begin
            if (ovf_set)         overflow_q <= 1'b1;
            else if (clr_status) overflow_q <= 1'b0;
            if (clr_status)                           fe_cnt_q <= 8'h00;
            else if (rx_frame_err && fe_cnt_q != 8'hFF) fe_cnt_q <= fe_cnt_q + 8'd1;
        end
    end

    assign rx_full       = full;
    assign empty         = (level_q == '0);
    assign level         = level_q;
    assign irq           = (irq_thresh != '0) && (level_q >= irq_thresh);
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign overflow      = overflow_q;
    assign frame_err_cnt = fe_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_uart_rx_fifo;

    logic       clk, rst_n;
    logic [7:0] rx_data;
    logic       rx_done, rx_frame_err, rx_finish, rx_full;
    logic       rd_en, rd_valid, empty, irq, overflow, clr_status;
    logic [7:0] rd_data, frame_err_cnt;
    logic [4:0] level, irq_thresh;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_frame_err  (rx_frame_err),
        .rx_finish     (rx_finish),
        .rx_full       (rx_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .level         (level),
        .irq_thresh    (irq_thresh),
        .irq           (irq),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt),
        .clr_status    (clr_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Byte in, one cycle in ACK, back in IDLE.
    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop(input logic [7:0] e);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_valid", {31'd0, rd_valid}, 32'd1);
        chk("pop_data", {24'd0, rd_data}, {24'd0, e});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_level"}, {27'd0, level}, 32'd0);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, "_full"}, {31'd0, rx_full}, 32'd0);
        chk({tag, "_finish"}, {31'd0, rx_finish}, 32'd0);
        chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_fecnt"}, {24'd0, frame_err_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rx_frame_err = 1'b0;
        rd_en = 1'b0; irq_thresh = 5'd0; clr_status = 1'b0;
        tick(); tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single byte round trip.
        rx_data = 8'hA5; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("single_finish", {31'd0, rx_finish}, 32'd1);
        chk("single_level", {27'd0, level}, 32'd1);
        chk("single_empty", {31'd0, empty}, 32'd0);
        tick();
        chk("single_finish_drop", {31'd0, rx_finish}, 32'd0);
        pop(8'hA5);
        chk("single_level0", {27'd0, level}, 32'd0);
        chk("single_empty1", {31'd0, empty}, 32'd1);
        tick();
        chk("single_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Read while empty is ignored and rd_data holds.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("empty_rd_data", {24'd0, rd_data}, 32'hA5);
        chk("empty_rd_level", {27'd0, level}, 32'd0);

        // Fill, partial drain, refill across the pointer wrap.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", {31'd0, rx_full}, 32'd1);
        chk("fill_level", {27'd0, level}, 32'd16);
        for (int i = 0; i < 8; i++) pop(8'(i));
        chk("drain_full", {31'd0, rx_full}, 32'd0);
        for (int i = 16; i < 24; i++) push(8'(i));
        chk("refill_level", {27'd0, level}, 32'd16);
        for (int i = 8; i < 24; i++) pop(8'(i));
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Back-pressure: byte waits in PEND until a read frees a slot.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        rx_data = 8'h3C; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("bp_no_finish", {31'd0, rx_finish}, 32'd0);
        chk("bp_level", {27'd0, level}, 32'd16);
        tick(); tick();
        chk("bp_still_stalled", {31'd0, rx_finish}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("bp_rd_data", {24'd0, rd_data}, 32'h20);
        chk("bp_level15", {27'd0, level}, 32'd15);
        chk("bp_finish_r1", {31'd0, rx_finish}, 32'd0);
        tick();
        chk("bp_finish_r2", {31'd0, rx_finish}, 32'd1);
        chk("bp_level16", {27'd0, level}, 32'd16);
        tick();
        chk("bp_finish_off", {31'd0, rx_finish}, 32'd0);
        chk("bp_no_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 16; i++) pop(8'(8'h20 + i));
        pop(8'h3C);

        // Threshold interrupt.
        irq_thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        chk("irq_lvl3", {31'd0, irq}, 32'd0);
        push(8'h43);
        chk("irq_lvl4", {31'd0, irq}, 32'd1);
        pop(8'h40);
        chk("irq_after_read", {31'd0, irq}, 32'd0);
        for (int i = 1; i < 4; i++) pop(8'(8'h40 + i));
        irq_thresh = 5'd0;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // Simultaneous read and write at level 5.
        rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        chk("simul_level", {27'd0, level}, 32'd5);
        chk("simul_rd_data", {24'd0, rd_data}, 32'h50);
        chk("simul_finish", {31'd0, rx_finish}, 32'd1);
        tick();
        for (int i = 1; i < 6; i++) pop(8'(8'h50 + i));

        // Frame errors, overflow and clearing.
        for (int i = 0; i < 3; i++) begin
            rx_frame_err = 1'b1; tick();
            rx_frame_err = 1'b0; tick();
        end
        chk("fe_cnt3", {24'd0, frame_err_cnt}, 32'd3);
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        rx_data = 8'h70; rx_done = 1'b1;
        tick();
        chk("pend_ovf_clear", {31'd0, overflow}, 32'd0);
        rx_data = 8'h71;
        tick();
        rx_done = 1'b0;
        chk("pend_ovf_set", {31'd0, overflow}, 32'd1);
        chk("pend_ovf_level", {27'd0, level}, 32'd16);
        chk("pend_ovf_finish", {31'd0, rx_finish}, 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_fecnt", {24'd0, frame_err_cnt}, 32'd0);

        // Reset while a byte is pending.
        rx_frame_err = 1'b1; tick(); rx_frame_err = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_finish", {31'd0, rx_finish}, 32'd0);
        chk("post_rst_level", {27'd0, level}, 32'd0);

        // Saturation, then clear beats a coincident increment.
        rx_frame_err = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("fe_sat", {24'd0, frame_err_cnt}, 32'd255);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0; rx_frame_err = 1'b0;
        chk("clr_beats_inc", {24'd0, frame_err_cnt}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the UART receiver and upstream of the bus/register interface. Captures each completed byte on the receiver's done pulse, stores it in a DEPTH-entry circular FIFO, and returns the rx_finish acknowledge that releases the receiver back to idle. Drives the receiver's rx_full back-pressure input, and provides a registered read port, a level count, a threshold interrupt, and sticky overflow/frame-error status for software.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, 4: log2(DEPTH); level is AW+1 bits wide.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid when rx_done=1 and held stable until rx_finish.
- rx_done  in  1  one-cycle pulse: byte complete.
- rx_frame_err  in  1  one-cycle pulse: stop bit was low, so no byte is delivered.
- rx_finish  out  1  one-cycle acknowledge to the receiver: byte consumed.
- rx_full  out  1  FIFO full (level==DEPTH), registered.
- rd_en  in  1  read-pop request from the bus side.
- rd_data  out  8  popped byte, registered.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- empty  out  1  level==0.
- level  out  AW+1  current occupancy, 0..DEPTH.
- irq_thresh  in  AW+1  interrupt threshold; 0 disables the interrupt.
- irq  out  1  registered, level-sensitive: level>=irq_thresh and irq_thresh!=0.
- overflow  out  1  sticky: a byte was lost.
- frame_err_cnt  out  8  saturating count of rx_frame_err pulses.
- clr_status  in  1  one-cycle pulse: clears overflow and frame_err_cnt.

## Operation
- Storage: 8-bit x DEPTH array, write pointer wp and read pointer rp, each AW bits, wrapping modulo DEPTH. level is a separate AW+1 counter.
- Write FSM states:
  - IDLE: on rx_done, capture rx_data into hold_reg. If level<DEPTH, write hold_reg at wp, increment wp, go ACK. Otherwise go PEND.
  - PEND: wait for a slot. When level<DEPTH, write hold_reg, then go ACK. rx_finish stays 0 while in PEND, so the receiver stalls.
  - ACK: rx_finish=1 for exactly this cycle, then go IDLE.
- rx_done arriving in PEND or ACK is a protocol violation: set overflow, discard the byte, and keep the state unchanged.
- Read: when rd_en=1 and level>0, rd_data<=mem[rp], rp++, and rd_valid=1 on the next cycle. When rd_en=1 and level==0, the read is ignored: rd_valid=0 and rd_data holds its value.
- level update per cycle: +1 on write only, -1 on read only, unchanged when both happen in the same cycle.
- A simultaneous read and write at level==DEPTH is impossible, because writes require level<DEPTH. In PEND, the write occurs in the cycle after the read frees a slot.
- frame_err_cnt increments on rx_frame_err and saturates at 255.
- clr_status coinciding with an increment: clear wins. clr_status coinciding with an overflow set: set wins.
- Unused FSM encodings go to IDLE.

## Timing
- Reset (async assert, sync-released use): state=IDLE, wp=rp=0, level=0, empty=1, rx_full=0, rx_finish=0, rd_data=0x00, rd_valid=0, irq=0, overflow=0, frame_err_cnt=0, hold_reg=0.
- Non-full write path:
  - rx_done at cycle N.
  - Memory write and level+1 visible at N+1.
  - rx_finish=1 during N+1.
- Full path:
  - Read at cycle R frees a slot, so level<DEPTH at R+1.
  - Write at R+1.
  - rx_finish=1 at R+2.
- Read latency: rd_en at cycle N gives rd_data/rd_valid at N+1.
- rx_full, empty and irq follow level with zero additional cycles. They are derived from registered level, so they reflect the state after the edge.
- Reset mid-operation: the FIFO contents are lost, and a pending byte is dropped without rx_finish. The receiver is reset by the same rst_n.

## Test plan
- Single byte: rx_done with rx_data=0xA5 -> rx_finish pulse one cycle later, level=1, empty=0. Then rd_en -> rd_data=0xA5, rd_valid one cycle later, level=0, empty=1.
- Fill and wrap: 16 bytes 0x00..0x0F -> rx_full=1 and level=16. Drain 8 and write 8 more (0x10..0x17) -> read order 0x08..0x17, with pointers wrapping correctly.
- Back-pressure: FIFO full, rx_done with 0x3C -> no rx_finish and the FSM stays in PEND. One rd_en -> the byte is written the next cycle, rx_finish pulses the cycle after that, and 0x3C is the last entry read.
- Threshold irq: irq_thresh=4 -> irq=0 at level 3, irq=1 at level 4, and irq=0 after one read. irq_thresh=0 -> irq never asserts.
- Status: 3 rx_frame_err pulses -> frame_err_cnt=3. rx_done during PEND -> overflow=1. clr_status -> both fields cleared. 300 frame-error pulses -> count saturates at 255.
- Corner cases: simultaneous rd_en and write at level=5 -> level stays 5. rd_en while empty -> rd_valid=0. Reset asserted while in PEND -> all outputs return to their reset values.
